fm_op_wave: RTL and testbench
=============================

// Module: fm_op_wave
// PURPOSE
// Operator output stage of the FM synth, directly downstream of fm_eg. Per operator slot it keeps a
// 19-bit phase accumulator, adds the phase increment and the modulation input, and reads a log-sine
// ROM. It adds the envelope attenuation (fm_eg env) and converts the result back to linear with an
// exp ROM. Produces one signed sample per operator on the same op_sel/next time-multiplex as fm_eg.
// PARAMETERS
// NUM_OPS   36   operator slots time-multiplexed (phase RAM depth; op_sel < NUM_OPS)
// PIPE_LAT  4    fixed latency next -> out_valid (documented constant; RTL must match, not tunable)
// PORTS
// clk         in   1   system clock
// reset       in   1   synchronous, active-high reset
// op_sel      in   6   operator slot index, valid when next=1
// next        in   1   one-cycle strobe: process op_sel this cycle (back-to-back cycles allowed)
// op_reset    in   1   qualified by next: clear slot phase to 0
// restart     in   1   qualified by next: key-on restart, clear slot phase to 0
// block       in   3   octave
// fnum        in   10  frequency number
// mult        in   4   frequency multiplier code
// ws          in   2   waveform select: 0 sine, 1 half-sine, 2 abs-sine, 3 quarter-sine
// modulation  in   10  phase offset from modulator/feedback, added modulo 1024
// env         in   9   attenuation from fm_eg (0 = loudest, 511 = silent)
// out_valid   out  1   sample valid strobe
// out_op      out  6   op_sel belonging to out_sample
// out_sample  out  13  signed two's-complement operator output
// BEHAVIOUR
// - Clock clk only. reset is synchronous and active-high. Reset drives out_valid=0, out_op=0,
//   out_sample=0 and flushes all pipeline valids. Reset does not clear the phase RAM.
// - Phase (S0, cycle of next): P = phase_ram[op_sel] (async read); if op_reset|restart, P=0.
//   Write back: P + inc (wrap 19 bits). When op_reset|restart, write inc.
// - inc = ((fnum << block) * MT[mult]) >> 1, truncated to 19 bits.
//   MT = {1,2,4,6,8,10,12,14,16,18,20,20,24,24,30,30}.
// - S1 (reg): idx = P[18:9] + modulation (mod 1024).
//   q = idx[8] ? ~idx[7:0] : idx[7:0]; neg = idx[9].
//   zero = (ws==1 & idx[9]) | (ws==3 & idx[8]).
//   neg is forced to 0 when ws is 2 or 3.
// - S2 (reg): ls = LS[q], where LS[i] = round(-256*log2(sin((i+0.5)*pi/512))), 12 bits.
//   LS[255]=0, LS[0]=2137.
// - S3 (reg): att = ls + {env,3'b000}, 13 bits. Max 6225, so no overflow. m = M[att[7:0]], where
//   M[i] = round(2048*2^(-i/256)), 12 bits (M[0]=2048). Register m and sh = att[12:8].
// - S4 (reg): mag = m >> sh (sh >= 12 gives 0).
//   out_sample = zero ? 0 : (neg ? -mag : mag). out_op = op_sel delayed; out_valid = next delayed.
// - Latency: out_valid is high exactly 4 cycles after next. One output per next, order preserved.
// - env, ws, modulation, block, fnum and mult are all sampled at next. The pipeline carries them
//   as needed, so inputs may change every cycle.
// - Same op_sel on consecutive next: the second access reads the value written by the first
//   (write-first bypass required).
// - next=0: the phase RAM is not written and the pipeline bubble propagates.
//   out_sample holds its last value while out_valid=0.
// - op_reset and restart together: same as either alone. Neither has any effect without next.
// TESTING
// 1. reset, then next op 0 with restart, env=0, ws=0, modulation=0x100 -> 4 cycles later
//    out_valid=1, out_op=0, out_sample=+2048.
// 2. fnum=0x200, block=4, mult=1: restart then 3 nexts on op 5 ->
//    stored phase 0x2000, 0x4000, 0x6000 (idx 0x10, 0x20, 0x30).
// 3. modulation=0x300, env=0, ws=0 -> -2048; same with ws=1 -> 0; ws=2 -> +2048.
// 4. idx=0x100 peak, env=32 -> +1024; env=511 -> 0.
//    next every cycle over ops 0..35 -> 36 contiguous out_valid with out_op in order.
// 5. Back-to-back next on op 7 twice (inc=0x2000 from 0) -> idx 0x00 then 0x10
//    (bypass verified). reset asserted with 3 samples in flight -> no out_valid afterwards.

Source files
------------

// File: rtl/fm_op_wave.sv
// fm_op_wave: operator output stage. Per-slot 19-bit phase accumulator, log-sine lookup,
// envelope attenuation and exp conversion to a signed linear sample. Four register stages
// from next to out_valid; one sample per next strobe, order preserved.
module fm_op_wave #(
  parameter int unsigned NUM_OPS = 36
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op_sel,
  input  logic        next,
  input  logic        op_reset,
  input  logic        restart,
  input  logic [2:0]  block,
  input  logic [9:0]  fnum,
  input  logic [3:0]  mult,
  input  logic [1:0]  ws,
  input  logic [9:0]  modulation,
  input  logic [8:0]  env,
  output logic        out_valid,
  output logic [5:0]  out_op,
  output logic [12:0] out_sample
);

  localparam int unsigned PH_W   = 19;
  localparam int unsigned IDX_W  = 10;
  localparam int unsigned Q_W    = 8;
  localparam int unsigned LS_W   = 12;
  localparam int unsigned ENV_W  = 9;
  localparam int unsigned ATT_W  = 13;
  localparam int unsigned M_W    = 12;
  localparam int unsigned SH_W   = 5;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned OUT_W  = 13;
  localparam int unsigned FSH_W  = 17;
  localparam int unsigned PROD_W = 22;
  localparam int unsigned MT_W   = 5;
  localparam int unsigned ROM_N  = 256;
  localparam real         PI     = 3.14159265358979323846;

  // Frequency multiplier table, index 0 first (rightmost).
  localparam logic [15:0][MT_W-1:0] MT = {
    5'd30, 5'd30, 5'd24, 5'd24, 5'd20, 5'd20, 5'd18, 5'd16,
    5'd14, 5'd12, 5'd10, 5'd8,  5'd6,  5'd4,  5'd2,  5'd1
  };

  // Quarter-wave log-sine table, evaluated at elaboration only.
  function automatic logic [ROM_N-1:0][LS_W-1:0] gen_logsin();
    logic [ROM_N-1:0][LS_W-1:0] t;
    real s;
    t = '0;
    for (int i = 0; i < int'(ROM_N); i++) begin
      s = $sin((real'(i) + 0.5) * PI / 512.0);
      t[i] = LS_W'($rtoi(-256.0 * $ln(s) / $ln(2.0) + 0.5));
    end
    return t;
  endfunction

  // Fractional exponent table 2048*2^(-i/256), evaluated at elaboration only.
  function automatic logic [ROM_N-1:0][M_W-1:0] gen_exp();
    logic [ROM_N-1:0][M_W-1:0] t;
    t = '0;
    for (int i = 0; i < int'(ROM_N); i++) begin
      t[i] = M_W'($rtoi(2048.0 * $pow(2.0, -real'(i) / 256.0) + 0.5));
    end
    return t;
  endfunction

  localparam logic [ROM_N-1:0][LS_W-1:0] LOGSIN_ROM = gen_logsin();
  localparam logic [ROM_N-1:0][M_W-1:0]  EXP_ROM    = gen_exp();

  logic [PH_W-1:0]   phase_ram [NUM_OPS];
  logic              op_in_range;
  logic              ph_clear;
  logic [FSH_W-1:0]  fnum_sh;
  logic [PROD_W-1:0] inc_prod;
  logic [PH_W-1:0]   ph_inc;
  logic [PH_W-1:0]   ph_cur;
  logic [IDX_W-1:0]  idx;

  logic              v1, neg1, zero1;
  logic [OP_W-1:0]   op1;
  logic [Q_W-1:0]    q1;
  logic [ENV_W-1:0]  env1;

  logic              v2, neg2, zero2;
  logic [OP_W-1:0]   op2;
  logic [LS_W-1:0]   ls2;
  logic [ENV_W-1:0]  env2;

  logic              v3, neg3, zero3;
  logic [OP_W-1:0]   op3;
  logic [M_W-1:0]    m3;
  logic [SH_W-1:0]   sh3;

  logic [ATT_W-1:0]  att;
  logic [M_W-1:0]    mag;
  logic [OUT_W-1:0]  sample_nxt;

  // S0: phase increment and current phase read (cleared slots read as zero).
  always_comb begin
    op_in_range = (op_sel < OP_W'(NUM_OPS));
    ph_clear    = op_reset | restart;
    fnum_sh     = FSH_W'(fnum) << block;
    inc_prod    = PROD_W'(fnum_sh) * PROD_W'(MT[mult]);
    ph_inc      = PH_W'(inc_prod >> 1);
    ph_cur      = '0;
    if (!ph_clear && op_in_range) begin
      ph_cur = phase_ram[op_sel];
    end
    idx = ph_cur[PH_W-1:PH_W-IDX_W] + modulation;
  end

  // Phase RAM write-back; not touched by reset. Next-cycle async read sees this write.
  always_ff @(posedge clk) begin
    if (next && op_in_range) begin
      phase_ram[op_sel] <= ph_cur + ph_inc;
    end
  end

  // S1: fold phase into quarter-wave index, derive sign and waveform zeroing.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1    <= 1'b0;
      op1   <= '0;
      q1    <= '0;
      neg1  <= 1'b0;
      zero1 <= 1'b0;
      env1  <= '0;
    end else begin
      v1    <= next;
      op1   <= op_sel;
      q1    <= idx[8] ? ~idx[7:0] : idx[7:0];
      neg1  <= idx[9] & ~ws[1];
      zero1 <= ((ws == 2'd1) & idx[9]) | ((ws == 2'd3) & idx[8]);
      env1  <= env;
    end
  end

  // S2: log-sine lookup.
  always_ff @(posedge clk) begin
    if (reset) begin
      v2    <= 1'b0;
      op2   <= '0;
      ls2   <= '0;
      neg2  <= 1'b0;
      zero2 <= 1'b0;
      env2  <= '0;
    end else begin
      v2    <= v1;
      op2   <= op1;
      ls2   <= LOGSIN_ROM[q1];
      neg2  <= neg1;
      zero2 <= zero1;
      env2  <= env1;
    end
  end

  // S3 attenuation sum; S4 shift and sign application.
  always_comb begin
    att        = ATT_W'(ls2) + ATT_W'({env2, 3'b000});
    mag        = m3 >> sh3;
    sample_nxt = '0;
    if (!zero3) begin
      sample_nxt = neg3 ? (OUT_W'(0) - OUT_W'(mag)) : OUT_W'(mag);
    end
  end

  // S3: exp lookup of the fractional part, keep integer part as shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      v3    <= 1'b0;
      op3   <= '0;
      m3    <= '0;
      sh3   <= '0;
      neg3  <= 1'b0;
      zero3 <= 1'b0;
    end else begin
      v3    <= v2;
      op3   <= op2;
      m3    <= EXP_ROM[att[7:0]];
      sh3   <= att[12:8];
      neg3  <= neg2;
      zero3 <= zero2;
    end
  end

  // S4: output register; sample and op hold while no valid sample arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_op     <= '0;
      out_sample <= '0;
    end else begin
      out_valid <= v3;
      if (v3) begin
        out_op     <= op3;
        out_sample <= sample_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fm_op_wave.sv
// tb_fm_op_wave: directed and randomized checks of fm_op_wave against a behavioural model.
module tb_fm_op_wave;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op_sel;
  logic        next;
  logic        op_reset;
  logic        restart;
  logic [2:0]  block;
  logic [9:0]  fnum;
  logic [3:0]  mult;
  logic [1:0]  ws;
  logic [9:0]  modulation;
  logic [8:0]  env;
  logic        out_valid;
  logic [5:0]  out_op;
  logic [12:0] out_sample;

  always #5 clk = ~clk;

  fm_op_wave dut (
    .clk        (clk),
    .reset      (reset),
    .op_sel     (op_sel),
    .next       (next),
    .op_reset   (op_reset),
    .restart    (restart),
    .block      (block),
    .fnum       (fnum),
    .mult       (mult),
    .ws         (ws),
    .modulation (modulation),
    .env        (env),
    .out_valid  (out_valid),
    .out_op     (out_op),
    .out_sample (out_sample)
  );

  typedef struct {
    int due;
    int op;
    int smp;
  } exp_t;

  localparam real PI = 3.14159265358979323846;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   last_smp = 0;
  int   ls_t [256];
  int   m_t  [256];
  int   ph_m [36];
  int   mt_t [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 20, 24, 24, 30, 30};

  // Reference sample for a 10-bit phase index, waveform and envelope.
  function automatic int ref_sample(input int idx, input int w, input int ev);
    int p, q, att, mag;
    p   = idx % 512;
    q   = (p < 256) ? p : 511 - p;
    att = ls_t[q] + ev * 8;
    mag = m_t[att % 256] / (1 << (att / 256));
    case (w)
      0:       return (idx >= 512) ? -mag : mag;
      1:       return (idx >= 512) ? 0 : mag;
      2:       return mag;
      default: return (p >= 256) ? 0 : mag;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive one cycle of inputs; on next, advance the model and queue the expected sample.
  task automatic drive(input int op, input bit nx, input bit orst, input bit rs, input int blk,
                       input int fn, input int ml, input int w, input int md, input int ev);
    int p, inc, idx;
    op_sel     = 6'(op);
    next       = nx;
    op_reset   = orst;
    restart    = rs;
    block      = 3'(blk);
    fnum       = 10'(fn);
    mult       = 4'(ml);
    ws         = 2'(w);
    modulation = 10'(md);
    env        = 9'(ev);
    if (nx) begin
      p        = (orst || rs) ? 0 : ph_m[op];
      inc      = (((fn << blk) * mt_t[ml]) / 2) % (1 << 19);
      ph_m[op] = (p + inc) % (1 << 19);
      idx      = ((p / 512) + md) % 1024;
      exp_q.push_back('{due: cyc + 4, op: op, smp: ref_sample(idx, w, ev)});
    end
  endtask

  // No strobe; all other inputs randomized, including clears that must have no effect.
  task automatic idle();
    drive($urandom_range(0, 35), 1'b0, 1'($urandom), 1'($urandom), $urandom_range(0, 7),
          $urandom_range(0, 1023), $urandom_range(0, 15), $urandom_range(0, 3),
          $urandom_range(0, 1023), $urandom_range(0, 511));
  endtask

  // Issue one strobe and wait (bounded) for its output; reports latency, op and sample.
  task automatic one_shot(input int op, input bit rs, input int blk, input int fn, input int ml,
                          input int w, input int md, input int ev,
                          output int lat, output int o_op, output int o_smp);
    drive(op, 1'b1, 1'b0, rs, blk, fn, ml, w, md, ev);
    lat   = -1;
    o_op  = -1;
    o_smp = 0;
    for (int i = 1; i <= 10 && lat < 0; i++) begin
      tick();
      idle();
      if (out_valid === 1'b1) begin
        lat   = i;
        o_op  = int'(out_op);
        o_smp = int'($signed(out_sample));
      end
    end
    last_smp = exp_q[0].smp;
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%b expected=0", out_valid);
    end
    checks++;
    if (out_op !== 6'd0) begin
      errors++; $display("FAIL reset_op got=%0d expected=0", out_op);
    end
    checks++;
    if (out_sample !== 13'd0) begin
      errors++; $display("FAIL reset_sample got=%0d expected=0", $signed(out_sample));
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      idle();
      checks++;
      if (out_valid !== 1'b0 || out_sample !== 13'd0) begin
        errors++;
        $display("FAIL post_reset_idle got valid=%b sample=%0d expected valid=0 sample=0",
                 out_valid, $signed(out_sample));
      end
    end
  endtask

  // Peak/sign/zeroing per waveform and envelope scaling, from a cleared phase.
  task automatic test_waveforms();
    int tw [11] = '{0, 0, 1, 2, 3, 1, 0, 0, 0, 3, 0};
    int tm [11] = '{'h100, 'h300, 'h300, 'h300, 'h300, 'h100, 'h100, 'h100, 'h100, 'h0FF, 'h2FF};
    int te [11] = '{0, 0, 0, 0, 0, 0, 32, 511, 256, 0, 0};
    int tx [11] = '{2048, -2048, 0, 2048, 0, 2048, 1024, 0, 8, 2048, -2048};
    int lat, o, s;
    for (int i = 0; i < 11; i++) begin
      one_shot(i, 1'b1, 0, 0, 0, tw[i], tm[i], te[i], lat, o, s);
      checks++;
      if (lat != 4 || o != i || s != tx[i]) begin
        errors++;
        $display("FAIL waveform[%0d] got lat=%0d op=%0d sample=%0d expected lat=4 op=%0d sample=%0d",
                 i, lat, o, s, i, tx[i]);
      end
    end
  endtask

  // Restart then three further strobes on op 5 with inc 0x2000: idx 0x00,0x10,0x20,0x30.
  task automatic test_phase_accum();
    int lat, o, s, e;
    for (int k = 0; k < 4; k++) begin
      one_shot(5, k == 0, 4, 'h200, 1, 0, 0, 0, lat, o, s);
      e = ref_sample(16 * k, 0, 0);
      checks++;
      if (lat != 4 || o != 5 || s != e) begin
        errors++;
        $display("FAIL phase_step[%0d] got lat=%0d op=%0d sample=%0d expected lat=4 op=5 sample=%0d",
                 k, lat, o, s, e);
      end
    end
  endtask

  // Two consecutive strobes on op 7: the second must see the first's write-back.
  task automatic test_back_to_back();
    int c0, n;
    int got_t [4];
    int got_s [4];
    c0 = cyc;
    drive(7, 1'b1, 1'b0, 1'b1, 4, 'h200, 1, 0, 0, 0);
    tick();
    drive(7, 1'b1, 1'b0, 1'b0, 4, 'h200, 1, 0, 0, 0);
    tick();
    idle();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid === 1'b1 && n < 4) begin
        got_t[n] = cyc - c0;
        got_s[n] = int'($signed(out_sample));
        n++;
      end
      tick();
      idle();
    end
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL b2b_count got=%0d expected=2", n);
    end else begin
      checks++;
      if (got_t[0] != 4 || got_s[0] != ref_sample(0, 0, 0)) begin
        errors++;
        $display("FAIL b2b_first got lat=%0d sample=%0d expected lat=4 sample=%0d",
                 got_t[0], got_s[0], ref_sample(0, 0, 0));
      end
      checks++;
      if (got_t[1] != 5 || got_s[1] != ref_sample('h10, 0, 0)) begin
        errors++;
        $display("FAIL b2b_bypass got lat=%0d sample=%0d expected lat=5 sample=%0d",
                 got_t[1], got_s[1], ref_sample('h10, 0, 0));
      end
    end
    last_smp = exp_q[1].smp;
    exp_q.delete();
  endtask

  // Strobe every cycle over all slots (with restart): 36 contiguous outputs in order.
  task automatic test_all_ops();
    for (int i = 0; i < 42; i++) begin
      if (i < 36) begin
        drive(i, 1'b1, 1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 7),
              $urandom_range(0, 1023), $urandom_range(0, 15), $urandom_range(0, 3),
              $urandom_range(0, 1023), $urandom_range(0, 63));
      end else begin
        idle();
      end
      tick();
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        checks++;
        if (out_valid !== 1'b1 || out_op !== 6'(exp_q[0].op) || out_sample !== 13'(exp_q[0].smp)) begin
          errors++;
          $display("FAIL all_ops cyc=%0d got valid=%b op=%0d sample=%0d expected valid=1 op=%0d sample=%0d",
                   cyc, out_valid, out_op, $signed(out_sample), exp_q[0].op, exp_q[0].smp);
        end
        last_smp = exp_q[0].smp;
        void'(exp_q.pop_front());
      end else begin
        checks++;
        if (out_valid !== 1'b0 || out_sample !== 13'(last_smp)) begin
          errors++;
          $display("FAIL all_ops_idle cyc=%0d got valid=%b sample=%0d expected valid=0 sample=%0d",
                   cyc, out_valid, $signed(out_sample), last_smp);
        end
      end
    end
  endtask

  // Random strobes, repeated ops, sporadic clears, inputs changing every cycle.
  task automatic test_random(input int n);
    int op;
    int prev_op = 0;
    for (int i = 0; i < n + 6; i++) begin
      if (i < n && $urandom_range(0, 9) < 7) begin
        op = ($urandom_range(0, 3) == 0) ? prev_op : int'($urandom_range(0, 35));
        drive(op, 1'b1, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 7), $urandom_range(0, 1023), $urandom_range(0, 15),
              $urandom_range(0, 3), $urandom_range(0, 1023),
              $urandom_range(0, 1) ? $urandom_range(0, 511) : $urandom_range(0, 40));
        prev_op = op;
      end else begin
        idle();
      end
      tick();
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        checks++;
        if (out_valid !== 1'b1 || out_op !== 6'(exp_q[0].op) || out_sample !== 13'(exp_q[0].smp)) begin
          errors++;
          $display("FAIL random cyc=%0d got valid=%b op=%0d sample=%0d expected valid=1 op=%0d sample=%0d",
                   cyc, out_valid, out_op, $signed(out_sample), exp_q[0].op, exp_q[0].smp);
        end
        last_smp = exp_q[0].smp;
        void'(exp_q.pop_front());
      end else begin
        checks++;
        if (out_valid !== 1'b0 || out_sample !== 13'(last_smp)) begin
          errors++;
          $display("FAIL random_idle cyc=%0d got valid=%b sample=%0d expected valid=0 sample=%0d",
                   cyc, out_valid, $signed(out_sample), last_smp);
        end
      end
    end
  endtask

  // Reset with three samples in flight: none may emerge; phase RAM survives.
  task automatic test_reset_flush();
    int lat, o, s, e;
    for (int i = 0; i < 3; i++) begin
      drive(10 + i, 1'b1, 1'b0, 1'b0, $urandom_range(0, 7), $urandom_range(0, 1023),
            $urandom_range(0, 15), 0, $urandom_range(0, 1023), 0);
      tick();
    end
    idle();
    reset = 1'b1;
    tick();
    idle();
    tick();
    reset = 1'b0;
    exp_q.delete();
    last_smp = 0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b0 || out_sample !== 13'd0) begin
        errors++;
        $display("FAIL flush cyc=%0d got valid=%b sample=%0d expected valid=0 sample=0",
                 cyc, out_valid, $signed(out_sample));
      end
      tick();
      idle();
    end
    e = ref_sample(((ph_m[11] / 512) + 'h40) % 1024, 0, 0);
    one_shot(11, 1'b0, 0, 0, 0, 0, 'h40, 0, lat, o, s);
    checks++;
    if (lat != 4 || o != 11 || s != e) begin
      errors++;
      $display("FAIL post_flush got lat=%0d op=%0d sample=%0d expected lat=4 op=11 sample=%0d",
               lat, o, s, e);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ls_t[i] = $rtoi(-256.0 * $ln($sin((real'(i) + 0.5) * PI / 512.0)) / $ln(2.0) + 0.5);
      m_t[i]  = $rtoi(2048.0 * $pow(2.0, -real'(i) / 256.0) + 0.5);
    end
    for (int i = 0; i < 36; i++) ph_m[i] = 0;
    test_reset();
    test_waveforms();
    test_phase_accum();
    test_back_to_back();
    test_all_ops();
    test_random(400);
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
